// File: rtl/uart_hamming_rx_pkg.sv
// Shared definitions for the UART receiver feeding the Hamming(13,8) decoder:
// FSM state encoding, codeword width and the baud divider computation.
package uart_hamming_rx_pkg;

  // Codeword width shared with the Hamming encoder and decoder
  localparam int CODEWORD_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, never below 1
  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator. tick pulses for one clk every DIV clks while clr is
// low; clr holds the divider at phase zero so the first tick lands DIV clks after
// clr drops. Shared by the receiver and the transmitter.
module uart_baud_tick
  import uart_hamming_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, restarted by clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_hamming_rx.sv
// UART receiver for 13-bit Hamming codewords: start + FRAME_BITS code bits (LSB
// first) + stop, oversampled, presented on a single-entry valid/ready buffer.
// Optional build macro RX_MAJORITY_EN: each bit decision is a 2-of-3 vote of
// rx_s at sub-counts MID-1, MID, MID+1, taken at MID+1.
module uart_hamming_rx
  import uart_hamming_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = CODEWORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  framing_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int MID = OVERSAMPLE / 2 - 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(FRAME_BITS);
`ifdef RX_MAJORITY_EN
  localparam int DEC = MID + 1;
`else
  localparam int DEC = MID;
`endif

  logic                  rx_meta;
  logic                  rx_s;
  rx_state_t             state;
  logic [SW-1:0]         sub;
  logic [IW-1:0]         idx;
  logic [FRAME_BITS-1:0] shreg;
  logic                  tick;
  logic                  sample_en;
  logic                  bit_val;

  // Two-flop synchronizer; idles high so reset does not look like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state == ST_IDLE),
    .tick(tick)
  );

  assign sample_en = tick && (sub == SW'(DEC));

`ifdef RX_MAJORITY_EN
  logic vote_a;
  logic vote_b;

  // Capture the two early votes; the third is rx_s live at the decision tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (tick) begin
      if (sub == SW'(MID - 1)) vote_a <= rx_s;
      if (sub == SW'(MID))     vote_b <= rx_s;
    end
  end

  assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // Deframing FSM with the output buffer and its pulse flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      sub           <= '0;
      idx           <= '0;
      shreg         <= '0;
      frame_out     <= '0;
      frame_valid   <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (frame_valid && frame_ready) frame_valid <= 1'b0;
      if (tick) sub <= (sub == SW'(OVERSAMPLE - 1)) ? '0 : sub + 1'b1;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            busy  <= 1'b1;
            sub   <= '0;
          end
        end
        ST_START: begin
          if (sample_en) begin
            if (bit_val) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DATA;
              idx   <= '0;
            end
          end
        end
        ST_DATA: begin
          if (sample_en) begin
            shreg[idx] <= bit_val;
            if (idx == IW'(FRAME_BITS - 1)) state <= ST_STOP;
            else                            idx   <= idx + 1'b1;
          end
        end
        ST_STOP: begin
          if (sample_en) begin
            if (bit_val) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              // A frame may load when the buffer is empty or being emptied this clk
              if (!frame_valid || frame_ready) begin
                frame_out   <= shreg;
                frame_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state         <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hamming_rx.sv
// Directed bench for uart_hamming_rx at DIV=1 (16 clks per bit).
module tb_uart_hamming_rx;

  localparam int CLK_FREQ = 1_843_200;
  localparam int BAUD     = 115_200;
  localparam int OS       = 16;
  localparam int FB       = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          frame_ready;
  logic [FB-1:0] frame_out;
  logic          frame_valid;
  logic          framing_error;
  logic          overrun;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor counters
  int            valid_cycles = 0;
  int            n_acc        = 0;
  int            n_fe         = 0;
  int            n_ov         = 0;
  logic [FB-1:0] last_frame   = '0;

  uart_hamming_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS),
    .FRAME_BITS(FB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .frame_out    (frame_out),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) valid_cycles++;
      if (frame_valid && frame_ready) begin
        n_acc++;
        last_frame = frame_out;
      end
      if (framing_error) n_fe++;
      if (overrun) n_ov++;
    end
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  // One bit time; optional inverted spike on the centre sample
  task automatic send_bit(input logic v, input bit spike);
    for (int m = 0; m < OS; m++) begin
      @(negedge clk);
      rx = (spike && m == 8) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [FB-1:0] d, input logic stop, input bit spike);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < FB; i++) send_bit(d[i], spike);
    send_bit(stop, 1'b0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 frame_ready = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({frame_valid, framing_error, overrun, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000", {frame_valid, framing_error, overrun, busy});
    end
    n_tests++;
    if (frame_out !== 13'h0000) begin
      n_fail++;
      $display("FAIL reset_frame_out: got %h required 0000", frame_out);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_single_frame();
    int v0, a0, f0, o0;
    v0 = valid_cycles; a0 = n_acc; f0 = n_fe; o0 = n_ov;
    send_frame(13'h1A5B, 1'b1, 1'b0);
    drive(1'b1, 8);
    n_tests++;
    if (last_frame !== 13'h1A5B) begin
      n_fail++;
      $display("FAIL single_data: got %h required 1a5b", last_frame);
    end
    n_tests++;
    if (valid_cycles - v0 !== 1) begin
      n_fail++;
      $display("FAIL single_valid_len: got %0d required 1", valid_cycles - v0);
    end
    n_tests++;
    if ((n_fe - f0) + (n_ov - o0) !== 0 || n_acc - a0 !== 1) begin
      n_fail++;
      $display("FAIL single_flags: fe %0d ov %0d acc %0d required 0 0 1", n_fe - f0, n_ov - o0, n_acc - a0);
    end
  endtask

  task automatic test_back_to_back();
    int a0, o0;
    set_ready(1'b0);
    a0 = n_acc; o0 = n_ov;
    send_frame(13'h0001, 1'b1, 1'b0);
    send_frame(13'h1FFF, 1'b1, 1'b0);
    drive(1'b1, 8);
    n_tests++;
    if (frame_out !== 13'h0001 || frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_held: got %h valid %b required 0001 valid 1", frame_out, frame_valid);
    end
    n_tests++;
    if (n_ov - o0 !== 1 || n_acc - a0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_overrun: ov %0d acc %0d required 1 0", n_ov - o0, n_acc - a0);
    end
    set_ready(1'b1);
    drive(1'b1, 3);
    n_tests++;
    if (frame_valid !== 1'b0 || last_frame !== 13'h0001) begin
      n_fail++;
      $display("FAIL b2b_drain: valid %b last %h required 0 0001", frame_valid, last_frame);
    end
    send_frame(13'h0AAA, 1'b1, 1'b0);
    drive(1'b1, 8);
    n_tests++;
    if (last_frame !== 13'h0AAA || n_acc - a0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_next: got %h acc %0d required 0aaa 2", last_frame, n_acc - a0);
    end
  endtask

  task automatic test_framing_error();
    int v0, f0;
    v0 = valid_cycles; f0 = n_fe;
    send_frame(13'h0F0F, 1'b0, 1'b0);
    drive(1'b0, 40 * OS);
    n_tests++;
    if (n_fe - f0 !== 1) begin
      n_fail++;
      $display("FAIL fe_pulse: got %0d required 1", n_fe - f0);
    end
    n_tests++;
    if (valid_cycles - v0 !== 0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fe_no_valid: got %0d cycles required 0", valid_cycles - v0);
    end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fe_break_busy: got %b required 1", busy);
    end
    drive(1'b1, 6);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fe_release_idle: got %b required 0", busy);
    end
  endtask

  task automatic test_glitch();
    int a0, f0;
    a0 = n_acc; f0 = n_fe;
    drive(1'b1, 16);
    drive(1'b0, 4);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start_seen: got %b required 1", busy);
    end
    drive(1'b1, 40);
    n_tests++;
    if (busy !== 1'b0 || n_acc - a0 !== 0 || n_fe - f0 !== 0) begin
      n_fail++;
      $display("FAIL glitch_false_start: busy %b acc %0d fe %0d required 0 0 0", busy, n_acc - a0, n_fe - f0);
    end
    send_frame(13'h1234, 1'b1, 1'b0);
    drive(1'b1, 8);
    n_tests++;
    if (last_frame !== 13'h1234 || n_acc - a0 !== 1) begin
      n_fail++;
      $display("FAIL glitch_next_frame: got %h acc %0d required 1234 1", last_frame, n_acc - a0);
    end
  endtask

  task automatic test_mid_reset();
    logic [FB-1:0] d;
    int a0;
    d = 13'h1555;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(d[i], 1'b0);
    drive(d[6], 5);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_busy: got %b required 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({frame_valid, framing_error, overrun, busy} !== 4'b0000 || frame_out !== 13'h0000) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: flags %b frame %h required 0000 0000",
               {frame_valid, framing_error, overrun, busy}, frame_out);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32);
    a0 = n_acc;
    send_frame(13'h0ACE, 1'b1, 1'b0);
    drive(1'b1, 8);
    n_tests++;
    if (last_frame !== 13'h0ACE || n_acc - a0 !== 1) begin
      n_fail++;
      $display("FAIL rst_after_frame: got %h acc %0d required 0ace 1", last_frame, n_acc - a0);
    end
  endtask

  task automatic test_spike();
    logic [FB-1:0] exp;
`ifdef RX_MAJORITY_EN
    exp = 13'h155A;
`else
    exp = 13'h0AA5;
`endif
    send_frame(13'h155A, 1'b1, 1'b1);
    drive(1'b1, 8);
    n_tests++;
    if (last_frame !== exp) begin
      n_fail++;
      $display("FAIL spike_data: got %h required %h", last_frame, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_framing_error();
    test_glitch();
    test_mid_reset();
    test_spike();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
